uart_rx_ctrl: RTL and testbench

UART receive sequencer that drives the 9600-baud bit-timing counter and turns its mid-bit strobe into received bytes. It synchronises the serial input and detects the start-bit falling edge. It holds the timing counter's count-enable high for the duration of a frame, then samples start, data, optional parity and stop bits on each strobe. It sits between the RX pin and the byte consumer (command parser / FIFO) in the 50 MHz UART path.

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_rx_sync_edge.sv | 24 ++
 rtl/uart_rx_ctrl.sv | 125 ++++++++++++
 tb/tb_uart_rx_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART constants: state codes, default frame width and bit-timing values.
package uart_pkg;

  localparam int unsigned DataBitsDef = 8;
  localparam int unsigned BPS_T       = 5208;
  localparam int unsigned BPS_MID     = 2604;

  typedef logic [2:0] rx_state_t;

  localparam rx_state_t StIdle   = 3'd0;
  localparam rx_state_t StStart  = 3'd1;
  localparam rx_state_t StData   = 3'd2;
  localparam rx_state_t StParity = 3'd3;
  localparam rx_state_t StStop   = 3'd4;
  localparam rx_state_t StDone   = 3'd5;

endpackage

// File: rtl/uart_rx_sync_edge.sv
// Two-flop synchroniser for the RX pin plus a third stage for falling-edge detection.
module uart_rx_sync_edge (
  input  logic CLK,
  input  logic RSTn,
  input  logic rx_pin,
  output logic rx_sync,
  output logic fall_edge
);

  // [0] first sync flop, [1] synced line, [2] previous synced value
  logic [2:0] stage_q;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      stage_q <= 3'b111;
    end else begin
      stage_q <= {stage_q[1:0], rx_pin};
    end
  end

  assign rx_sync   = stage_q[1];
  assign fall_edge = ~stage_q[1] & stage_q[2];

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer driving an external bit-timing counter.
// Optional parity checking is compiled in with `define RX_PARITY_EN.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS  = DataBitsDef,
  parameter bit          PARITY_ODD = 1'b0
) (
  input  logic                 CLK,
  input  logic                 RSTn,
  input  logic                 RX_Pin_In,
  input  logic                 RX_En_Sig,
  input  logic                 BPS_CLK,
  output logic                 Count_Sig,
  output logic [DATA_BITS-1:0] RX_Data,
  output logic                 RX_Done_Sig,
  output logic                 RX_Err_Sig
);

  localparam int unsigned IdxW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  logic                 rx_sync;
  logic                 fall_edge;
  rx_state_t            state_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [IdxW-1:0]      idx_q;
  logic                 perr_q;
  logic                 last_bit;

  uart_rx_sync_edge u_sync_edge (
    .CLK       (CLK),
    .RSTn      (RSTn),
    .rx_pin    (RX_Pin_In),
    .rx_sync   (rx_sync),
    .fall_edge (fall_edge)
  );

  assign last_bit = (idx_q == IdxW'(DATA_BITS - 1));

`ifdef RX_PARITY_EN
  localparam rx_state_t StAfterData = StParity;
  logic parity_exp;
  assign parity_exp = (^shift_q) ^ PARITY_ODD;
`else
  localparam rx_state_t StAfterData = StStop;
  logic unused_parity_cfg;
  assign unused_parity_cfg = PARITY_ODD;
  assign perr_q            = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q     <= StIdle;
      Count_Sig   <= 1'b0;
      RX_Done_Sig <= 1'b0;
      RX_Err_Sig  <= 1'b0;
      RX_Data     <= '0;
      shift_q     <= '0;
      idx_q       <= '0;
`ifdef RX_PARITY_EN
      perr_q      <= 1'b0;
`endif
    end else begin
      RX_Done_Sig <= 1'b0;
      case (state_q)
        StIdle: begin
          if (fall_edge && RX_En_Sig) begin
            state_q   <= StStart;
            Count_Sig <= 1'b1;
`ifdef RX_PARITY_EN
            perr_q    <= 1'b0;
`endif
          end
        end
        StStart: begin
          if (BPS_CLK) begin
            // A high line at mid start bit means the edge was a glitch
            if (rx_sync) begin
              state_q   <= StIdle;
              Count_Sig <= 1'b0;
            end else begin
              state_q <= StData;
              idx_q   <= '0;
            end
          end
        end
        StData: begin
          if (BPS_CLK) begin
            shift_q[idx_q] <= rx_sync;
            idx_q          <= idx_q + IdxW'(1);
            if (last_bit) begin
              state_q <= StAfterData;
            end
          end
        end
`ifdef RX_PARITY_EN
        StParity: begin
          if (BPS_CLK) begin
            perr_q  <= (rx_sync != parity_exp);
            state_q <= StStop;
          end
        end
`endif
        StStop: begin
          // Results are registered here so they are valid during the Done cycle
          if (BPS_CLK) begin
            RX_Data     <= shift_q;
            RX_Err_Sig  <= ~rx_sync | perr_q;
            RX_Done_Sig <= 1'b1;
            Count_Sig   <= 1'b0;
            state_q     <= StDone;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q   <= StIdle;
          Count_Sig <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl with a scaled-down bit-timing counter.
module tb_uart_rx_ctrl;

  localparam int unsigned DataBits  = 8;
  localparam bit          ParityOdd = 1'b0;
  localparam int unsigned Bit       = 16;
  localparam int unsigned Mid       = 8;
`ifdef RX_PARITY_EN
  localparam int unsigned ParBits   = 1;
`else
  localparam int unsigned ParBits   = 0;
`endif
  localparam int unsigned FrameBits = 2 + DataBits + ParBits;

  logic                CLK       = 1'b0;
  logic                RSTn      = 1'b1;
  logic                RX_Pin_In = 1'b1;
  logic                RX_En_Sig = 1'b0;
  logic                BPS_CLK;
  logic                Count_Sig;
  logic [DataBits-1:0] RX_Data;
  logic                RX_Done_Sig;
  logic                RX_Err_Sig;

  int          checks  = 0;
  int          errors  = 0;
  int unsigned cyc     = 0;
  int unsigned bps_cnt = 0;

  typedef struct {
    logic [DataBits-1:0] data;
    logic                err;
    logic                cnt;
    int unsigned         cyc;
  } done_t;
  done_t got_q[$];

  always #10 CLK = ~CLK;

  uart_rx_ctrl #(
    .DATA_BITS  (DataBits),
    .PARITY_ODD (ParityOdd)
  ) dut (
    .CLK         (CLK),
    .RSTn        (RSTn),
    .RX_Pin_In   (RX_Pin_In),
    .RX_En_Sig   (RX_En_Sig),
    .BPS_CLK     (BPS_CLK),
    .Count_Sig   (Count_Sig),
    .RX_Data     (RX_Data),
    .RX_Done_Sig (RX_Done_Sig),
    .RX_Err_Sig  (RX_Err_Sig)
  );

  // Bit-timing counter model: strobe at Mid, then every Bit cycles while enabled
  always @(posedge CLK) begin
    cyc <= cyc + 1;
    if (!Count_Sig) bps_cnt <= 0;
    else bps_cnt <= (bps_cnt == Bit - 1) ? 0 : bps_cnt + 1;
  end
  assign BPS_CLK = Count_Sig && (bps_cnt == Mid);

  always @(posedge CLK) begin
    #1;
    if (RX_Done_Sig === 1'b1) got_q.push_back('{RX_Data, RX_Err_Sig, Count_Sig, cyc});
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  function automatic logic model_err(input logic [DataBits-1:0] d, input logic pbit,
                                     input logic stop);
    return !stop || (ParBits == 1 && pbit != ((^d) ^ ParityOdd));
  endfunction

  function automatic logic good_par(input logic [DataBits-1:0] d);
    return (^d) ^ ParityOdd;
  endfunction

  task automatic drive_bits(input logic [DataBits-1:0] d, input logic pbit, input logic stop,
                            input int unsigned nbits);
    logic bits[$];
    bits.push_back(1'b0);
    for (int i = 0; i < DataBits; i++) bits.push_back(d[i]);
    if (ParBits == 1) bits.push_back(pbit);
    bits.push_back(stop);
    for (int i = 0; i < nbits && i < bits.size(); i++) begin
      RX_Pin_In = bits[i];
      repeat (Bit) @(negedge CLK);
    end
  endtask

  task automatic idle_bits(input int unsigned n);
    RX_Pin_In = 1'b1;
    repeat (n * Bit) @(negedge CLK);
  endtask

  task automatic wait_done(input int unsigned n);
    int unsigned budget = 0;
    while (got_q.size() < n && budget < 4 * FrameBits * Bit) begin
      @(negedge CLK);
      budget++;
    end
  endtask

  task automatic test_reset();
    #1 RSTn = 1'b0;
    repeat (3) @(negedge CLK);
    checks++; if (Count_Sig !== 1'b0) begin errors++;
      $display("FAIL reset_count: got %b, want 0", Count_Sig); end
    checks++; if (RX_Done_Sig !== 1'b0) begin errors++;
      $display("FAIL reset_done: got %b, want 0", RX_Done_Sig); end
    checks++; if (RX_Err_Sig !== 1'b0) begin errors++;
      $display("FAIL reset_err: got %b, want 0", RX_Err_Sig); end
    checks++; if (RX_Data !== '0) begin errors++;
      $display("FAIL reset_data: got %h, want 00", RX_Data); end
    RSTn = 1'b1;
    RX_En_Sig = 1'b1;
    idle_bits(1);
  endtask

  task automatic test_basic();
    got_q.delete();
    drive_bits(8'h55, good_par(8'h55), 1'b1, FrameBits);
    idle_bits(2);
    wait_done(1);
    checks++; if (got_q.size() !== 1) begin errors++;
      $display("FAIL basic_count: got %0d pulses, want 1", got_q.size()); end
    if (got_q.size() > 0) begin
      checks++; if (got_q[0].data !== 8'h55) begin errors++;
        $display("FAIL basic_data: got %h, want 55", got_q[0].data); end
      checks++; if (got_q[0].err !== 1'b0) begin errors++;
        $display("FAIL basic_err: got %b, want 0", got_q[0].err); end
      checks++; if (got_q[0].cnt !== 1'b0) begin errors++;
        $display("FAIL basic_count_sig_at_done: got %b, want 0", got_q[0].cnt); end
    end
  endtask

  task automatic test_glitch();
    got_q.delete();
    RX_Pin_In = 1'b0;
    repeat (2) @(negedge CLK);
    RX_Pin_In = 1'b1;
    repeat (2) @(negedge CLK);
    checks++; if (Count_Sig !== 1'b1) begin errors++;
      $display("FAIL glitch_start: Count_Sig got %b, want 1", Count_Sig); end
    idle_bits(2);
    checks++; if (got_q.size() !== 0) begin errors++;
      $display("FAIL glitch_done: got %0d pulses, want 0", got_q.size()); end
    checks++; if (Count_Sig !== 1'b0) begin errors++;
      $display("FAIL glitch_count: got %b, want 0", Count_Sig); end
    checks++; if (RX_Data !== 8'h55) begin errors++;
      $display("FAIL glitch_data: got %h, want 55", RX_Data); end
  endtask

  task automatic test_stop_err();
    got_q.delete();
    drive_bits(8'hA3, good_par(8'hA3), 1'b0, FrameBits);
    idle_bits(2);
    wait_done(1);
    checks++; if (got_q.size() !== 1) begin errors++;
      $display("FAIL stop_err_count: got %0d pulses, want 1", got_q.size()); end
    if (got_q.size() > 0) begin
      checks++; if (got_q[0].data !== 8'hA3) begin errors++;
        $display("FAIL stop_err_data: got %h, want a3", got_q[0].data); end
      checks++; if (got_q[0].err !== 1'b1) begin errors++;
        $display("FAIL stop_err_flag: got %b, want 1", got_q[0].err); end
    end
  endtask

  task automatic test_back_to_back();
    got_q.delete();
    drive_bits(8'h00, good_par(8'h00), 1'b1, FrameBits);
    drive_bits(8'hFF, good_par(8'hFF), 1'b1, FrameBits);
    idle_bits(2);
    wait_done(2);
    checks++; if (got_q.size() !== 2) begin errors++;
      $display("FAIL b2b_count: got %0d pulses, want 2", got_q.size()); end
    if (got_q.size() > 1) begin
      checks++; if (got_q[0].data !== 8'h00 || got_q[0].err !== 1'b0) begin errors++;
        $display("FAIL b2b_first: got %h/%b, want 00/0", got_q[0].data, got_q[0].err); end
      checks++; if (got_q[1].data !== 8'hFF || got_q[1].err !== 1'b0) begin errors++;
        $display("FAIL b2b_second: got %h/%b, want ff/0", got_q[1].data, got_q[1].err); end
      checks++; if (got_q[1].cyc - got_q[0].cyc !== FrameBits * Bit) begin errors++;
        $display("FAIL b2b_spacing: got %0d cycles, want %0d", got_q[1].cyc - got_q[0].cyc,
                 FrameBits * Bit); end
    end
  endtask

  task automatic test_enable();
    got_q.delete();
    RX_En_Sig = 1'b0;
    drive_bits(8'h81, good_par(8'h81), 1'b1, FrameBits);
    idle_bits(2);
    checks++; if (got_q.size() !== 0) begin errors++;
      $display("FAIL enable_gate: got %0d pulses, want 0", got_q.size()); end
    RX_En_Sig = 1'b1;
    fork
      drive_bits(8'h5A, good_par(8'h5A), 1'b1, FrameBits);
      begin
        repeat (3 * Bit) @(negedge CLK);
        RX_En_Sig = 1'b0;
      end
    join
    idle_bits(2);
    wait_done(1);
    RX_En_Sig = 1'b1;
    checks++; if (got_q.size() !== 1 || RX_Data !== 8'h5A) begin errors++;
      $display("FAIL enable_midframe: got %0d pulses data %h, want 1 pulse data 5a",
               got_q.size(), RX_Data); end
  endtask

  task automatic test_reset_mid();
    logic [DataBits-1:0] d = 8'hE7;
    got_q.delete();
    drive_bits(d, good_par(d), 1'b1, 5);
    RX_Pin_In = d[4];
    repeat (Bit / 2) @(negedge CLK);
    #5 RSTn = 1'b0;
    #1;
    checks++; if (Count_Sig !== 1'b0) begin errors++;
      $display("FAIL rstmid_count: got %b, want 0", Count_Sig); end
    checks++; if (RX_Data !== '0 || RX_Err_Sig !== 1'b0 || RX_Done_Sig !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_outputs: got data %h err %b done %b, want 00/0/0",
               RX_Data, RX_Err_Sig, RX_Done_Sig); end
    repeat (3) @(negedge CLK);
    RX_Pin_In = 1'b1;
    RSTn = 1'b1;
    idle_bits(2);
    checks++; if (got_q.size() !== 0) begin errors++;
      $display("FAIL rstmid_nodone: got %0d pulses, want 0", got_q.size()); end
    drive_bits(8'h3C, good_par(8'h3C), 1'b1, FrameBits);
    idle_bits(2);
    wait_done(1);
    checks++; if (got_q.size() !== 1 || RX_Data !== 8'h3C || RX_Err_Sig !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_next: got %0d pulses data %h err %b, want 1/3c/0",
               got_q.size(), RX_Data, RX_Err_Sig); end
  endtask

`ifdef RX_PARITY_EN
  task automatic test_parity();
    got_q.delete();
    drive_bits(8'h07, 1'b0, 1'b1, FrameBits);
    drive_bits(8'h07, 1'b1, 1'b1, FrameBits);
    idle_bits(2);
    wait_done(2);
    checks++; if (got_q.size() !== 2) begin errors++;
      $display("FAIL parity_count: got %0d pulses, want 2", got_q.size()); end
    if (got_q.size() > 1) begin
      checks++; if (got_q[0].err !== 1'b1) begin errors++;
        $display("FAIL parity_bad: got %b, want 1", got_q[0].err); end
      checks++; if (got_q[1].err !== 1'b0) begin errors++;
        $display("FAIL parity_good: got %b, want 0", got_q[1].err); end
    end
  endtask
`endif

  task automatic test_random();
    logic [DataBits-1:0] exp_d[$];
    logic                exp_e[$];
    logic [DataBits-1:0] d;
    logic                stop;
    logic                pbit;
    int unsigned         gap;
    got_q.delete();
    for (int n = 0; n < 8; n++) begin
      d    = DataBits'($urandom);
      stop = ($urandom_range(3) != 0);
      pbit = good_par(d) ^ ($urandom_range(3) == 0);
      gap  = $urandom_range(2);
      if (!stop && gap == 0) gap = 1;
      exp_d.push_back(d);
      exp_e.push_back(model_err(d, pbit, stop));
      drive_bits(d, pbit, stop, FrameBits);
      idle_bits(gap);
    end
    idle_bits(2);
    wait_done(8);
    checks++; if (got_q.size() !== 8) begin errors++;
      $display("FAIL random_count: got %0d pulses, want 8", got_q.size()); end
    for (int n = 0; n < 8 && n < got_q.size(); n++) begin
      checks++; if (got_q[n].data !== exp_d[n]) begin errors++;
        $display("FAIL random_data[%0d]: got %h, want %h", n, got_q[n].data, exp_d[n]); end
      checks++; if (got_q[n].err !== exp_e[n]) begin errors++;
        $display("FAIL random_err[%0d]: got %b, want %b", n, got_q[n].err, exp_e[n]); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_stop_err();
    test_back_to_back();
    test_enable();
    test_reset_mid();
`ifdef RX_PARITY_EN
    test_parity();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
